sync_fifo_gen: RTL and testbench
================================

Name: sync_fifo_gen

Overview:
Parametrised single-clock FIFO, the successor to the dual-clock FIFO. It keeps the same write/read port naming and adds programmable almost-full/almost-empty thresholds, an occupancy count and a first-word-fall-through (FWFT) mode. It also adds sticky overflow/underflow error flags and a synchronous flush. It is used wherever producer and consumer share one clock, and it is verified with the same class-based environment style as the async FIFO.

Parameters:
DSIZE, 8, data width in bits.
ASIZE, 3, address width; DEPTH = 2**ASIZE words.
AFULL_TH, 7, wr_almost_full asserts when count >= AFULL_TH (legal range 1..DEPTH).
AEMPTY_TH, 1, rd_almost_empty asserts when count <= AEMPTY_TH (legal range 0..DEPTH-1).
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous reset, active-low.
clr  in  1  synchronous flush, active-high.
wr_inc  in  1  write request.
wr_data  in  DSIZE  write data.
wr_full  out  1  FIFO holds DEPTH words.
wr_almost_full  out  1  count >= AFULL_TH.
rd_inc  in  1  read request.
rd_data  out  DSIZE  read data.
rd_valid  out  1  rd_data holds valid read data.
rd_empty  out  1  FIFO holds 0 words.
rd_almost_empty  out  1  count <= AEMPTY_TH.
count  out  ASIZE+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers = 0, count = 0.
  - rd_empty = 1, rd_almost_empty = 1.
  - wr_full = 0, wr_almost_full = 0 (AFULL_TH >= 1).
  - overflow = 0, underflow = 0, rd_valid = 0, rd_data = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Pointers: ASIZE+1-bit binary write and read pointers. Address = low ASIZE bits; the extra MSB disambiguates full from empty at wrap. count = wr_ptr - rd_ptr, modulo 2**(ASIZE+1).
- Write acceptance: wr_acc = wr_inc & ~wr_full. Read acceptance: rd_acc = rd_inc & ~rd_empty. Both are evaluated on the flags registered before the edge.
- Simultaneous events:
  - At full, the write is rejected and the read is accepted; count ends at DEPTH-1.
  - At empty, the read is rejected and the write is accepted; count ends at 1.
  - Otherwise a simultaneous accepted write and read leave count unchanged.
- All flags and count are registered and update on the same edge as the pointer change. A write at edge N makes rd_empty 0 after edge N.
- Error flags:
  - overflow is set by wr_inc & wr_full; underflow is set by rd_inc & rd_empty.
  - Both stay set until rst or clr.
  - A rejected access does not move a pointer.
- Standard mode (FWFT=0):
  - rd_data is registered with 1-cycle latency: rd_acc at edge N gives the word on rd_data after edge N+1.
  - rd_valid pulses for exactly that cycle.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_addr] combinationally whenever rd_empty = 0.
  - rd_valid = ~rd_empty.
  - rd_inc pops the head word and the next word appears after the edge.
- clr (synchronous, highest priority after rst):
  - Pointers and count go to 0, and all flags take their reset values.
  - Any write or read in the same cycle is discarded.
  - Memory is untouched.
- Threshold flags are computed from the next count, so they change on the same edge as count.

Decomposition:
- Shared package sync_fifo_pkg holds the read-mode constants FWFT_OFF/FWFT_ON and a helper function for the count width (ASIZE+1).
- One sub-module, sync_fifo_mem: a 2**ASIZE x DSIZE simple dual-port RAM with a synchronous write port, and a read port that is registered or combinational as selected by FWFT.

Test Plan:
- Reset mid-fill: with count=5, pulse rst low between edges -> count=0, rd_empty=1, wr_full=0, overflow=0 immediately, without waiting for a clock.
- Fill: DEPTH=8, write 0x01..0x08 with no reads -> wr_almost_full rises after the 7th write and wr_full after the 8th. A 9th write of 0xFF is ignored, overflow=1, count stays 8.
- Drain (FWFT=0): 8 back-to-back reads -> rd_data = 0x01..0x08, each one cycle after its rd_inc with rd_valid high. rd_almost_empty rises at count 1. A 9th read sets underflow=1 and count stays 0.
- Simultaneous access:
  - At count=4, wr_inc and rd_inc together -> count stays 4.
  - At count=8 -> read accepted, write rejected, count=7, overflow=1.
  - At count=0 -> write accepted, count=1, underflow=1.
- Wrap-around: 24 interleaved writes/reads of an incrementing pattern -> the output order is preserved across pointer wraps at 8 and 16, and wr_full never asserts falsely.
- FWFT=1 plus clr:
  - A single write of 0xA5 -> after that edge rd_empty=0, rd_valid=1, rd_data=0xA5 with no rd_inc.
  - Then fill to count=5 and assert clr -> next cycle count=0, rd_empty=1, overflow=underflow=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package sync_fifo_pkg;
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy needs one extra bit so that a full FIFO (DEPTH words) is representable.
  function automatic int cnt_w(input int asize);
    return asize + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered or combinational read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3,
  parameter int FWFT  = FWFT_OFF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  generate
    if (FWFT == FWFT_ON) begin : g_comb
      logic unused_re;
      assign unused_re = re;
      assign rdata     = mem_q[raddr];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (re) rdata_q <= mem_q[raddr];
      end
      assign rdata = rdata_q;
    end
  endgenerate
endmodule

// File: rtl/sync_fifo_gen.sv
// Single-clock FIFO with thresholds, occupancy, sticky error flags, flush and FWFT option.
module sync_fifo_gen
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = 7,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_inc,
  input  logic [DSIZE-1:0] wr_data,
  output logic             wr_full,
  output logic             wr_almost_full,
  input  logic             rd_inc,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int CW = cnt_w(ASIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(2**ASIZE);
  localparam logic [CW-1:0] AF_TH   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_TH   = CW'(AEMPTY_TH);
  localparam int RD_STAGES = 2;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic [DSIZE-1:0] mem_rdata;

  always_comb begin
    wr_acc   = wr_inc & ~full_q;
    rd_acc   = rd_inc & ~empty_q;
    wr_ptr_d = wr_ptr_q + (wr_acc ? CW'(1) : CW'(0));
    rd_ptr_d = rd_ptr_q + (rd_acc ? CW'(1) : CW'(0));
    ovf_d    = ovf_q | (wr_inc & full_q);
    unf_d    = unf_q | (rd_inc & empty_q);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
    // Flags come from the next occupancy so they move on the same edge as count.
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_TH);
    aempty_d = (count_d <= AE_TH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(FWFT)) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~clr),
    .waddr (wr_ptr_q[ASIZE-1:0]),
    .wdata (wr_data),
    .re    (rd_acc & ~clr),
    .raddr (rd_ptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign rd_data  = empty_q ? '0 : mem_rdata;
      assign rd_valid = ~empty_q;
    end else begin : g_std
      // Stage 1: RAM output register loaded; stage 2: presented on rd_data.
      logic [RD_STAGES:1] vld_pipe_q, vld_pipe_d;
      logic [DSIZE-1:0]   rd_data_q, rd_data_d;
      always_comb begin
        vld_pipe_d = {vld_pipe_q[1] & ~clr, rd_acc & ~clr};
        rd_data_d  = (vld_pipe_q[1] & ~clr) ? mem_rdata : rd_data_q;
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_pipe_q <= '0;
          rd_data_q  <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          rd_data_q  <= rd_data_d;
        end
      end
      assign rd_data  = rd_data_q;
      assign rd_valid = vld_pipe_q[RD_STAGES];
    end
  endgenerate

  assign count           = count_q;
  assign wr_full         = full_q;
  assign wr_almost_full  = afull_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = aempty_q;
  assign overflow        = ovf_q;
  assign underflow       = unf_q;
endmodule

// File: tb/tb_sync_fifo_gen.sv
// Bench: standard and FWFT instances on shared stimulus, checked against a queue model.
module tb_sync_fifo_gen;
  logic       clk = 1'b0, rst = 1'b0, clr = 1'b0, wr_inc = 1'b0, rd_inc = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       o0_full, o0_afull, o0_valid, o0_empty, o0_aempty, o0_ovf, o0_unf;
  logic       o1_full, o1_afull, o1_valid, o1_empty, o1_aempty, o1_ovf, o1_unf;
  logic [7:0] o0_data, o1_data;
  logic [3:0] o0_count, o1_count;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sync_fifo_gen #(.DSIZE(8), .ASIZE(3), .AFULL_TH(7), .AEMPTY_TH(1), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .wr_inc(wr_inc), .wr_data(wr_data),
    .wr_full(o0_full), .wr_almost_full(o0_afull), .rd_inc(rd_inc), .rd_data(o0_data),
    .rd_valid(o0_valid), .rd_empty(o0_empty), .rd_almost_empty(o0_aempty),
    .count(o0_count), .overflow(o0_ovf), .underflow(o0_unf));

  sync_fifo_gen #(.DSIZE(8), .ASIZE(3), .AFULL_TH(7), .AEMPTY_TH(1), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_inc(wr_inc), .wr_data(wr_data),
    .wr_full(o1_full), .wr_almost_full(o1_afull), .rd_inc(rd_inc), .rd_data(o1_data),
    .rd_valid(o1_valid), .rd_empty(o1_empty), .rd_almost_empty(o1_aempty),
    .count(o1_count), .overflow(o1_ovf), .underflow(o1_unf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus sticky flags and a 2-edge read delay line.
  logic [7:0] q[$];
  bit         m_ovf, m_unf, s1_v, exp_v, m_full, m_empty, m_pop;
  logic [7:0] s1_d, exp_d, pv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete(); m_ovf = 0; m_unf = 0; s1_v = 0; exp_v = 0; exp_d = 8'h00;
    end else if (clr) begin
      q.delete(); m_ovf = 0; m_unf = 0; s1_v = 0; exp_v = 0;
    end else begin
      m_full  = (q.size() == 8);
      m_empty = (q.size() == 0);
      if (wr_inc && m_full)  m_ovf = 1;
      if (rd_inc && m_empty) m_unf = 1;
      exp_v = s1_v;
      if (s1_v) exp_d = s1_d;
      m_pop = rd_inc && !m_empty;
      pv    = 8'h00;
      if (m_pop) pv = q.pop_front();
      if (wr_inc && !m_full) q.push_back(wr_data);
      s1_v = m_pop;
      s1_d = pv;
    end
  end

  always @(negedge clk) begin
    int n;
    logic [5:0] ef;
    n  = q.size();
    ef = {n == 0, n == 8, n >= 7, n <= 1, m_ovf, m_unf};
    chk("count_std",  32'(o0_count), 32'(n));
    chk("count_fwft", 32'(o1_count), 32'(n));
    chk("flags_std",  32'({o0_empty, o0_full, o0_afull, o0_aempty, o0_ovf, o0_unf}), 32'(ef));
    chk("flags_fwft", 32'({o1_empty, o1_full, o1_afull, o1_aempty, o1_ovf, o1_unf}), 32'(ef));
    chk("valid_std",  32'(o0_valid), 32'(exp_v));
    chk("data_std",   32'(o0_data),  32'(exp_d));
    chk("valid_fwft", 32'(o1_valid), 32'(n != 0));
    chk("data_fwft",  32'(o1_data),  (n != 0) ? 32'(q[0]) : 32'h0);
  end

  task automatic cyc(input bit wi, input logic [7:0] wd, input bit ri, input bit ci);
    @(negedge clk);
    wr_inc = wi; wr_data = wd; rd_inc = ri; clr = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw;
    logic [7:0] d;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(o0_count), 0);
    chk("rst_empty", 32'({o0_empty, o0_aempty, o1_empty, o1_aempty}), 32'hF);
    chk("rst_full",  32'({o0_full, o0_afull, o0_ovf, o0_unf}), 0);
    chk("rst_rd",    32'({o0_valid, o0_data}), 0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) cyc(1, 8'(i + 1), 0, 0);
    cyc(0, 0, 0, 0);
    chk("midfill_count", 32'(o0_count), 5);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(o0_count), 0);
    chk("async_rst_flags", 32'({o0_empty, o0_full, o0_ovf}), 32'b100);
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(i + 1), 0, 0);
      if (i == 5) chk("afull_at6", 32'(o0_afull), 0);
      if (i == 6) chk("afull_at7", 32'({o0_afull, o0_full}), 32'b10);
      if (i == 7) chk("full_at8",  32'({o0_afull, o0_full}), 32'b11);
    end
    cyc(1, 8'hFF, 0, 0);
    chk("ovf_9th", 32'({o0_ovf, o0_count}), 32'h18);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0);
      if (i > 0) chk("drain_data", 32'({o0_valid, o0_data}), 32'h100 | 32'(i));
      if (i == 5) chk("aempty_at2", 32'(o0_aempty), 0);
      if (i == 6) chk("aempty_at1", 32'(o0_aempty), 1);
    end
    cyc(0, 0, 1, 0);
    chk("drain_last", 32'({o0_valid, o0_data}), 32'h108);
    chk("unf_9th",    32'({o0_unf, o0_count}), 32'h10);
    cyc(0, 0, 0, 0);
    chk("valid_drop", 32'(o0_valid), 0);

    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'h30 + 8'(i), 0, 0);
    cyc(1, 8'h40, 1, 0);
    chk("simul_mid", 32'(o0_count), 4);
    for (int i = 0; i < 4; i++) cyc(1, 8'h41 + 8'(i), 0, 0);
    cyc(1, 8'h50, 1, 0);
    chk("simul_full", 32'({o0_ovf, o0_count}), 32'h17);
    cyc(0, 0, 0, 1);
    cyc(1, 8'h60, 1, 0);
    chk("simul_empty", 32'({o0_unf, o0_count}), 32'h11);
    chk("simul_empty_fwft", 32'(o1_data), 32'h60);

    cyc(0, 0, 0, 1);
    d = 8'h00;
    for (int i = 0; i < 3; i++) begin cyc(1, d, 0, 0); d++; end
    for (int i = 0; i < 24; i++) begin cyc(1, d, 1, 0); d++; end
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(1, 8'hA5, 0, 0);
    chk("fwft_a5", 32'({o1_empty, o1_valid, o1_data}), 32'h1A5);
    for (int i = 0; i < 4; i++) cyc(1, 8'hB0 + 8'(i), 0, 0);
    chk("fwft_cnt5", 32'(o1_count), 5);
    cyc(1, 8'h77, 1, 1);
    chk("clr_state", 32'({o1_count, o1_empty, o1_ovf, o1_unf}), 32'b0000100);

    for (int ph = 0; ph < 12; ph++) begin
      pw = int'($urandom_range(15, 85));
      for (int i = 0; i < 250; i++)
        cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 127) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
